// File: rtl/digit_scan_if.sv
// Bus between the digit scanner and its driver: load/data/lz_en in, display drive out.
interface digit_scan_if #(
   parameter int NDIG = 8
);
   localparam int IW = $clog2(NDIG);

   logic              load;
   logic [4*NDIG-1:0] data;
   logic              lz_en;
   logic [3:0]        digit;
   logic [NDIG-1:0]   an;
   logic              blank;
   logic [IW-1:0]     sel;
   logic              pend;

   modport master (
      output load, data, lz_en,
      input  digit, an, blank, sel, pend
   );

   modport slave (
      input  load, data, lz_en,
      output digit, an, blank, sel, pend
   );
endinterface

// File: rtl/digit_scan.sv
// Multiplexed seven-segment scanner: one digit per slot, shadowed loads committed
// only at frame boundaries, anti-ghost blanking and optional leading-zero blanking.
module digit_scan #(
   parameter int NDIG      = 8,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input logic         clk,
   input logic         rst,
   digit_scan_if.slave bus
);
   localparam int IW = $clog2(NDIG);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = 4 * NDIG;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

   logic [CW-1:0]   r_cnt;
   logic [IW-1:0]   r_idx;
   logic [DW-1:0]   r_disp;
   logic [DW-1:0]   r_shadow;
   logic            r_pend;
   logic [3:0]      r_digit;
   logic [NDIG-1:0] r_an;
   logic            r_blank;

   logic            w_slot_end;
   logic            w_frame_end;
   logic [CW-1:0]   w_cnt_nxt;
   logic [IW-1:0]   w_idx_nxt;
   logic [DW-1:0]   w_disp_nxt;
   logic [DW-1:0]   w_shadow_nxt;
   logic            w_pend_nxt;
   logic [NDIG-1:0] w_zero_above;
   logic [3:0]      w_digit_nxt;
   logic            w_supp;
   logic            w_lit;
   logic [NDIG-1:0] w_an_nxt;

   // Next-state sequencing; disp only ever moves on the frame boundary.
   always_comb begin
      w_slot_end   = (r_cnt == CNT_LAST);
      w_frame_end  = w_slot_end && (r_idx == IDX_LAST);
      w_cnt_nxt    = w_slot_end ? '0 : r_cnt + CW'(1);
      w_idx_nxt    = r_idx;
      if (w_slot_end)
         w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      w_disp_nxt   = r_disp;
      if (w_frame_end)
         w_disp_nxt = bus.load ? bus.data : r_shadow;
      w_shadow_nxt = bus.load ? bus.data : r_shadow;
      w_pend_nxt   = !w_frame_end && (bus.load || r_pend);
   end

   // Outputs are derived from next-state values so they line up with cnt/idx.
   always_comb begin
      logic w_run;
      w_run        = 1'b1;
      w_zero_above = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         w_run           = w_run && (w_disp_nxt[4*i +: 4] == 4'd0);
         w_zero_above[i] = w_run;
      end

      w_digit_nxt = '0;
      w_supp      = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (w_idx_nxt == IW'(i)) begin
            w_digit_nxt = w_disp_nxt[4*i +: 4];
            w_supp      = bus.lz_en && (i != 0) && w_zero_above[i];
         end
      end

      w_lit    = (w_cnt_nxt >= CW'(BLANK_CYC)) && !w_supp;
      w_an_nxt = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (w_lit && (w_idx_nxt == IW'(i)))
            w_an_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_disp   <= '0;
         r_shadow <= '0;
         r_pend   <= 1'b0;
         r_digit  <= '0;
         r_an     <= '1;
         r_blank  <= 1'b1;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_disp   <= w_disp_nxt;
         r_shadow <= w_shadow_nxt;
         r_pend   <= w_pend_nxt;
         r_digit  <= w_digit_nxt;
         r_an     <= w_an_nxt;
         r_blank  <= !w_lit;
      end
   end

   assign bus.digit = r_digit;
   assign bus.an    = r_an;
   assign bus.blank = r_blank;
   assign bus.sel   = r_idx;
   assign bus.pend  = r_pend;
endmodule

// File: tb/tb_digit_scan.sv
// Bench for digit_scan (NDIG=4, SCAN_DIV=8, BLANK_CYC=2): per-cycle expectations
// are queued as stimulus is driven and popped against the registered outputs.
module tb_digit_scan;
   localparam int NDIG      = 4;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = NDIG * SCAN_DIV;

   logic clk = 1'b0;
   logic rst;

   digit_scan_if #(.NDIG(NDIG)) bus ();

   digit_scan #(
      .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] digit;
      logic       blank;
      logic [1:0] sel;
      logic       pend;
   } out_t;

   out_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          ph;
   logic [15:0] m_disp, m_shadow;
   logic        m_pend;
   out_t        exp_o, obs;

   // Expected outputs for frame position p with displayed value dv.
   function automatic out_t expect_out(int p, logic [15:0] dv, bit lz, logic pd);
      out_t e;
      int s = p / SCAN_DIV;
      int c = p % SCAN_DIV;
      logic [15:0] hi = dv >> (4 * s);
      logic supp = lz && (s != 0) && (hi == 16'h0);
      e.sel   = 2'(s);
      e.digit = 4'(hi);
      e.pend  = pd;
      e.blank = (c < BLANK_CYC) || supp;
      e.an    = e.blank ? 4'hF : ~(4'b0001 << s);
      return e;
   endfunction

   function automatic out_t observe();
      return out_t'({bus.an, bus.digit, bus.blank, bus.sel, bus.pend});
   endfunction

   task automatic drive_cycle(input bit ld, input logic [15:0] d, input bit lz);
      rst = 1'b0;
      bus.load = ld; bus.data = d; bus.lz_en = lz;
      if (ph == FRAME - 1) begin
         m_disp = ld ? d : m_shadow;
         m_pend = 1'b0;
      end else begin
         m_pend = ld | m_pend;
      end
      if (ld) m_shadow = d;
      ph = (ph + 1) % FRAME;
      sb.push_back(expect_out(ph, m_disp, lz, m_pend));
      @(posedge clk); #1;
      bus.load = 1'b0;
   endtask

   task automatic reset_cycle(input bit ld);
      rst = 1'b1; bus.load = ld; bus.data = 16'hFFFF;
      m_disp = '0; m_shadow = '0; m_pend = 1'b0; ph = 0;
      sb.push_back('{an: 4'hF, digit: 4'h0, blank: 1'b1, sel: 2'd0, pend: 1'b0});
      @(posedge clk); #1;
      bus.load = 1'b0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         reset_cycle(1'b1);
         exp_o = sb.pop_front(); obs = observe(); n_chk++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL reset_hold: got %h required %h", obs, exp_o);
         end
      end
      for (int k = 0; k < 10; k++) begin
         drive_cycle(1'b0, 16'h0, 1'b0);
         exp_o = sb.pop_front(); obs = observe(); n_chk++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL reset_release: got %h required %h", obs, exp_o);
         end
         if (ph == 1) begin
            n_chk++;
            if (bus.an !== 4'hF) begin
               n_fail++; $display("FAIL reset_first_dark: an got %b required 1111", bus.an);
            end
         end
         if (ph == 2) begin
            n_chk++;
            if (bus.an !== 4'b1110 || bus.digit !== 4'h0) begin
               n_fail++; $display("FAIL reset_first_lit: an/digit got %b/%h required 1110/0", bus.an, bus.digit);
            end
         end
      end
   endtask

   task automatic test_basic_scan();
      logic [3:0] nib [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
      logic [3:0] ant [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      int  total = (FRAME - ph) + 2 * FRAME;
      bit  seen = 1'b0;
      for (int k = 0; k < total; k++) begin
         drive_cycle(k == 0, 16'h1A2F, 1'b0);
         if (ph == 0) seen = 1'b1;
         exp_o = sb.pop_front(); obs = observe(); n_chk++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL basic_scan: got %h required %h", obs, exp_o);
         end
         if (seen && (ph % SCAN_DIV) >= BLANK_CYC) begin
            n_chk++;
            if (bus.digit !== nib[ph / SCAN_DIV] || bus.an !== ant[ph / SCAN_DIV]) begin
               n_fail++;
               $display("FAIL basic_slot: digit/an got %h/%b required %h/%b",
                        bus.digit, bus.an, nib[ph / SCAN_DIV], ant[ph / SCAN_DIV]);
            end
         end
      end
   endtask

   task automatic test_tear_free();
      logic [3:0] nib [4] = '{4'h8, 4'h7, 4'h6, 4'h5};
      int  pre   = (8 - ph + FRAME) % FRAME;
      int  total = pre + (FRAME - 8) + 2 * FRAME;
      bit  seen  = 1'b0;
      for (int k = 0; k < total; k++) begin
         if (k == pre)          drive_cycle(1'b1, 16'h1234, 1'b0);
         else if (k == pre + 8) drive_cycle(1'b1, 16'h5678, 1'b0);
         else                   drive_cycle(1'b0, 16'h0, 1'b0);
         if (ph == 0 && k > pre) seen = 1'b1;
         exp_o = sb.pop_front(); obs = observe(); n_chk++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL tear_free: got %h required %h", obs, exp_o);
         end
         if (k >= pre && !seen) begin
            n_chk++;
            if (bus.pend !== 1'b1) begin
               n_fail++; $display("FAIL tear_pend_high: pend got %b required 1", bus.pend);
            end
         end
         if (seen) begin
            n_chk++;
            if (bus.digit !== nib[bus.sel] || bus.pend !== 1'b0) begin
               n_fail++;
               $display("FAIL tear_new_frame: digit/pend got %h/%b required %h/0",
                        bus.digit, bus.pend, nib[bus.sel]);
            end
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [15:0] val [2] = '{16'h0030, 16'h0000};
      int          top [2] = '{1, 0};
      for (int v = 0; v < 2; v++) begin
         int total = (FRAME - ph) + FRAME;
         bit seen  = 1'b0;
         for (int k = 0; k < total; k++) begin
            drive_cycle(k == 0, val[v], 1'b1);
            if (ph == 0) seen = 1'b1;
            exp_o = sb.pop_front(); obs = observe(); n_chk++;
            if (obs !== exp_o) begin
               n_fail++; $display("FAIL leading_zero: got %h required %h", obs, exp_o);
            end
            if (seen) begin
               logic [3:0] want = 4'hF;
               if ((ph % SCAN_DIV) >= BLANK_CYC && int'(bus.sel) <= top[v])
                  want = ~(4'b0001 << bus.sel);
               n_chk++;
               if (bus.an !== want) begin
                  n_fail++; $display("FAIL lz_anode: an got %b required %b", bus.an, want);
               end
            end
         end
      end
   endtask

   task automatic test_boundary_load();
      int pre   = (FRAME - 1 - ph + FRAME) % FRAME;
      int total = pre + 1 + FRAME;
      for (int k = 0; k < total; k++) begin
         drive_cycle(k == pre, 16'hBEEF, 1'b0);
         exp_o = sb.pop_front(); obs = observe(); n_chk++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL boundary_load: got %h required %h", obs, exp_o);
         end
         n_chk++;
         if (bus.pend !== 1'b0) begin
            n_fail++; $display("FAIL boundary_pend: pend got %b required 0", bus.pend);
         end
         if (k > pre && ph == BLANK_CYC) begin
            n_chk++;
            if (bus.digit !== 4'hF || bus.an !== 4'b1110) begin
               n_fail++; $display("FAIL boundary_slot0: digit/an got %h/%b required f/1110", bus.digit, bus.an);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int pre = (19 - ph + FRAME) % FRAME;
      for (int k = 0; k < pre; k++) begin
         drive_cycle(k == 0, 16'hC0DE, 1'b0);
         exp_o = sb.pop_front(); obs = observe(); n_chk++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL mid_reset_setup: got %h required %h", obs, exp_o);
         end
      end
      n_chk++;
      if (bus.pend !== 1'b1 || bus.sel !== 2'd2) begin
         n_fail++; $display("FAIL mid_reset_precond: pend/sel got %b/%0d required 1/2", bus.pend, bus.sel);
      end
      reset_cycle(1'b1);
      exp_o = sb.pop_front(); obs = observe(); n_chk++;
      if (obs !== exp_o) begin
         n_fail++; $display("FAIL mid_reset_state: got %h required %h", obs, exp_o);
      end
      for (int k = 0; k < 2 * FRAME + 4; k++) begin
         drive_cycle(1'b0, 16'h0, 1'b0);
         exp_o = sb.pop_front(); obs = observe(); n_chk++;
         if (obs !== exp_o) begin
            n_fail++; $display("FAIL mid_reset_after: got %h required %h", obs, exp_o);
         end
         n_chk++;
         if (bus.digit !== 4'h0 || bus.pend !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_zero: digit/pend got %h/%b required 0/0", bus.digit, bus.pend);
         end
      end
   endtask

   initial begin
      rst = 1'b1; bus.load = 1'b0; bus.data = '0; bus.lz_en = 1'b0;
      ph = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
      test_reset();
      test_basic_scan();
      test_tear_free();
      test_leading_zero();
      test_boundary_load();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
